// File: rtl/sbit_tap_scan_pkg.sv
// Shared definitions for the S-bit IDELAY tap scanner: scan FSM states,
// default geometry and the run-centre helper.
package sbit_tap_scan_pkg;

  localparam int NUM_VFATS_DEFAULT = 24;
  localparam int TAP_BITS_DEFAULT  = 5;
  // A run can span every tap (0..32), so one bit wider than a tap index.
  localparam int RUN_BITS          = TAP_BITS_DEFAULT + 1;
  // VFAT index width on the tap-load and readback interfaces.
  localparam int VFAT_IDX_BITS     = 5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SELECT = 4'd1,
    ST_LOAD   = 4'd2,
    ST_SETTLE = 4'd3,
    ST_COUNT  = 4'd4,
    ST_EVAL   = 4'd5,
    ST_CENTER = 4'd6,
    ST_NEXT   = 4'd7,
    ST_DONE   = 4'd8
  } scan_state_e;

  // Centre tap of a run: start + (len-1)/2. An empty run maps to tap 0.
  // The sum never exceeds the last tap because start+len-1 <= 31.
  function automatic logic [TAP_BITS_DEFAULT-1:0] run_center(
    input logic [TAP_BITS_DEFAULT-1:0] run_start,
    input logic [RUN_BITS-1:0]         run_len
  );
    logic [RUN_BITS-1:0] half;
    logic [RUN_BITS-1:0] sum;
    if (run_len == RUN_BITS'(0)) begin
      half = RUN_BITS'(0);
      sum  = RUN_BITS'(0);
    end else begin
      half = (run_len - RUN_BITS'(1)) >> 1;
      sum  = {1'b0, run_start} + half;
    end
    return sum[TAP_BITS_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/sbit_tap_scanner_tap_err_window.sv
// Error window counter for the tap scanner: counts err cycles over a window
// of 2^WINDOW_BITS enabled cycles. The tally saturates at all-ones so a
// noisy tap can never wrap back to looking clean.
module tap_err_window
  import sbit_tap_scan_pkg::*;
#(
  parameter int WINDOW_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset_i,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 err_bit,
  output logic [WINDOW_BITS:0] count,
  output logic                 window_done
);

  logic [WINDOW_BITS-1:0] cycle_r;
  logic [WINDOW_BITS:0]   count_r;

  // Window position: restarts on clear, advances on each enabled cycle.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      cycle_r <= '0;
    end else if (clear) begin
      cycle_r <= '0;
    end else if (enable) begin
      cycle_r <= cycle_r + WINDOW_BITS'(1);
    end
  end

  // Error tally: restarts on clear, increments on err, holds at all-ones.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && err_bit && (count_r != '1)) begin
      count_r <= count_r + (WINDOW_BITS + 1)'(1);
    end
  end

  assign count       = count_r;
  // High on the last cycle of the window.
  assign window_done = enable && (cycle_r == '1);

endmodule

// File: rtl/sbit_tap_scanner.sv
// Automatic IDELAY tap scanner for the trigger S-bit receivers.
// For each enabled VFAT it sweeps all 32 taps, counts errors in a fixed
// window per tap, finds the longest error-free run (earliest wins on ties),
// loads the run's centre tap back and stores it for readback.
// Optional build macro: SBIT_TAP_SCAN_EARLY_EXIT_EN -- leave a tap's count
// window as soon as the error count passes ERR_THRESH.
module sbit_tap_scanner
  import sbit_tap_scan_pkg::*;
#(
  parameter int NUM_VFATS     = NUM_VFATS_DEFAULT,
  parameter int TAP_BITS      = TAP_BITS_DEFAULT,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_BITS   = 10,
  parameter int ERR_THRESH    = 0
) (
  input  logic                     clock,
  input  logic                     reset_i,
  input  logic                     start,
  input  logic [NUM_VFATS-1:0]     vfat_enable,
  input  logic [NUM_VFATS-1:0]     err,
  output logic                     tap_load,
  output logic [VFAT_IDX_BITS-1:0] tap_vfat,
  output logic [TAP_BITS-1:0]      tap_value,
  output logic                     busy,
  output logic                     done,
  input  logic [VFAT_IDX_BITS-1:0] rd_vfat,
  output logic [TAP_BITS-1:0]      rd_center,
  output logic                     rd_valid
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]        SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [VFAT_IDX_BITS-1:0]   LAST_VFAT   = VFAT_IDX_BITS'(NUM_VFATS - 1);
  localparam logic [VFAT_IDX_BITS:0]     VFAT_COUNT  = (VFAT_IDX_BITS + 1)'(NUM_VFATS);
  localparam logic [TAP_BITS-1:0]        LAST_TAP    = '1;
  localparam logic [WINDOW_BITS:0]       THRESH      = (WINDOW_BITS + 1)'(ERR_THRESH);

  // FSM and scan datapath state
  scan_state_e              state_r;
  scan_state_e              state_nxt_s;
  logic [VFAT_IDX_BITS-1:0] idx_r;
  logic [TAP_BITS-1:0]      tap_r;
  logic [TAP_BITS-1:0]      run_start_r;
  logic [RUN_BITS-1:0]      run_len_r;
  logic [TAP_BITS-1:0]      best_start_r;
  logic [RUN_BITS-1:0]      best_len_r;
  logic [SETTLE_W-1:0]      settle_r;

  // Registered tap-load interface and status
  logic                     tap_load_r;
  logic [VFAT_IDX_BITS-1:0] tap_vfat_r;
  logic [TAP_BITS-1:0]      tap_value_r;
  logic                     busy_r;
  logic                     done_r;

  // Per-VFAT stored results
  logic [TAP_BITS-1:0]      center_mem_r [NUM_VFATS];
  logic [NUM_VFATS-1:0]     valid_mem_r;

  // Combinational helpers
  logic                     err_bit_s;
  logic                     win_clear_s;
  logic                     win_enable_s;
  logic [WINDOW_BITS:0]     win_count_s;
  logic                     win_done_s;
  logic                     tap_good_s;
  logic [TAP_BITS-1:0]      run_start_nxt_s;
  logic [RUN_BITS-1:0]      run_len_nxt_s;
  logic [TAP_BITS-1:0]      best_start_nxt_s;
  logic [RUN_BITS-1:0]      best_len_nxt_s;
  logic                     out_load_s;
  logic [TAP_BITS-1:0]      out_value_s;
  logic                     rd_in_range_s;
`ifdef SBIT_TAP_SCAN_EARLY_EXIT_EN
  logic                     early_hit_s;
`endif

  assign err_bit_s    = err[idx_r];
  // The window counter only runs during COUNT and is held clear otherwise,
  // so it starts from zero on the first COUNT cycle of every tap.
  assign win_clear_s  = (state_r != ST_COUNT);
  assign win_enable_s = (state_r == ST_COUNT);

  tap_err_window #(
    .WINDOW_BITS (WINDOW_BITS)
  ) u_window (
    .clock       (clock),
    .reset_i     (reset_i),
    .clear       (win_clear_s),
    .enable      (win_enable_s),
    .err_bit     (err_bit_s),
    .count       (win_count_s),
    .window_done (win_done_s)
  );

`ifdef SBIT_TAP_SCAN_EARLY_EXIT_EN
  // The tally will pass the threshold at the end of this cycle.
  assign early_hit_s = err_bit_s && (win_count_s >= THRESH) && (win_count_s != '1);
`endif

  // Run tracking for the tap being evaluated: extend or break the current
  // run, then promote it to best only when strictly longer (earliest wins).
  always_comb begin
    tap_good_s       = (win_count_s <= THRESH);
    run_start_nxt_s  = run_start_r;
    run_len_nxt_s    = RUN_BITS'(0);
    best_start_nxt_s = best_start_r;
    best_len_nxt_s   = best_len_r;
    if (tap_good_s) begin
      if (run_len_r == RUN_BITS'(0)) begin
        run_start_nxt_s = tap_r;
      end else begin
        run_start_nxt_s = run_start_r;
      end
      run_len_nxt_s = run_len_r + RUN_BITS'(1);
    end else begin
      run_len_nxt_s = RUN_BITS'(0);
    end
    if (run_len_nxt_s > best_len_r) begin
      best_start_nxt_s = run_start_nxt_s;
      best_len_nxt_s   = run_len_nxt_s;
    end else begin
      best_start_nxt_s = best_start_r;
      best_len_nxt_s   = best_len_r;
    end
  end

  // Next-state logic plus the tap-load request for the coming cycle.
  always_comb begin
    state_nxt_s = state_r;
    out_load_s  = 1'b0;
    out_value_s = tap_value_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SELECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (vfat_enable[idx_r]) begin
          state_nxt_s = ST_LOAD;
          out_load_s  = 1'b1;
          out_value_s = '0;
        end else begin
          state_nxt_s = ST_NEXT;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_r == SETTLE_LAST) begin
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_COUNT: begin
`ifdef SBIT_TAP_SCAN_EARLY_EXIT_EN
        if (win_done_s || early_hit_s) begin
          state_nxt_s = ST_EVAL;
        end else begin
          state_nxt_s = ST_COUNT;
        end
`else
        if (win_done_s) begin
          state_nxt_s = ST_EVAL;
        end else begin
          state_nxt_s = ST_COUNT;
        end
`endif
      end
      ST_EVAL: begin
        out_load_s = 1'b1;
        if (tap_r == LAST_TAP) begin
          // Centre strobe is issued during CENTER, so use the best run
          // as it will be after this evaluation.
          state_nxt_s = ST_CENTER;
          out_value_s = run_center(best_start_nxt_s, best_len_nxt_s);
        end else begin
          state_nxt_s = ST_LOAD;
          out_value_s = tap_r + TAP_BITS'(1);
        end
      end
      ST_CENTER: begin
        state_nxt_s = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_r == LAST_VFAT) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan datapath: VFAT index, tap sweep, settle timer and run trackers.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      idx_r        <= '0;
      tap_r        <= '0;
      run_start_r  <= '0;
      run_len_r    <= '0;
      best_start_r <= '0;
      best_len_r   <= '0;
      settle_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            idx_r <= '0;
          end
        end
        ST_SELECT: begin
          if (vfat_enable[idx_r]) begin
            tap_r        <= '0;
            run_start_r  <= '0;
            run_len_r    <= '0;
            best_start_r <= '0;
            best_len_r   <= '0;
          end
        end
        ST_LOAD: begin
          settle_r <= '0;
        end
        ST_SETTLE: begin
          settle_r <= settle_r + SETTLE_W'(1);
        end
        ST_EVAL: begin
          run_start_r  <= run_start_nxt_s;
          run_len_r    <= run_len_nxt_s;
          best_start_r <= best_start_nxt_s;
          best_len_r   <= best_len_nxt_s;
          if (tap_r != LAST_TAP) begin
            tap_r <= tap_r + TAP_BITS'(1);
          end
        end
        ST_NEXT: begin
          if (idx_r != LAST_VFAT) begin
            idx_r <= idx_r + VFAT_IDX_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; tap_vfat/tap_value hold between strobes, busy drops
  // on the cycle done pulses.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      tap_load_r  <= 1'b0;
      tap_vfat_r  <= '0;
      tap_value_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      tap_load_r <= out_load_s;
      if (out_load_s) begin
        tap_vfat_r  <= idx_r;
        tap_value_r <= out_value_s;
      end
      busy_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Result store: written once per enabled VFAT in CENTER.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_VFATS; i++) begin
        center_mem_r[i] <= '0;
      end
      valid_mem_r <= '0;
    end else if (state_r == ST_CENTER) begin
      center_mem_r[idx_r] <= run_center(best_start_r, best_len_r);
      valid_mem_r[idx_r]  <= (best_len_r != RUN_BITS'(0));
    end
  end

  assign rd_in_range_s = ({1'b0, rd_vfat} < VFAT_COUNT);
  assign rd_center     = rd_in_range_s ? center_mem_r[rd_vfat] : '0;
  assign rd_valid      = rd_in_range_s ? valid_mem_r[rd_vfat] : 1'b0;

  assign tap_load  = tap_load_r;
  assign tap_vfat  = tap_vfat_r;
  assign tap_value = tap_value_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sbit_tap_scanner.sv
// Scoreboard bench for sbit_tap_scanner. Each VFAT's err line follows a
// per-tap good/bad map indexed by the tap last loaded into it. At start
// the reference model pushes the expected tap-load sequence and done cycle;
// a negedge monitor pops and compares.
module tb_sbit_tap_scanner;

  localparam int NV     = 24;
  localparam int SETTLE = 4;
  localparam int WBITS  = 4;
  localparam int WIN    = 1 << WBITS;
  localparam int THR    = 0;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        start;
  logic [NV-1:0] vfat_enable;
  logic [NV-1:0] err;
  logic        tap_load;
  logic [4:0]  tap_vfat;
  logic [4:0]  tap_value;
  logic        busy;
  logic        done;
  logic [4:0]  rd_vfat;
  logic [4:0]  rd_center;
  logic        rd_valid;

  typedef struct { int vfat; int value; } load_t;

  load_t       exp_q[$];
  int          done_q[$];
  logic [31:0] bad [NV];
  logic [4:0]  cur_tap [NV];
  int          exp_center [NV];
  int          exp_valid [NV];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          forbid5 = 1'b0;
  bit          got_done;

  sbit_tap_scanner #(
    .NUM_VFATS(NV), .TAP_BITS(5), .SETTLE_CYCLES(SETTLE),
    .WINDOW_BITS(WBITS), .ERR_THRESH(THR)
  ) dut (
    .clock(clock), .reset_i(reset_i), .start(start), .vfat_enable(vfat_enable),
    .err(err), .tap_load(tap_load), .tap_vfat(tap_vfat), .tap_value(tap_value),
    .busy(busy), .done(done), .rd_vfat(rd_vfat), .rd_center(rd_center),
    .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  // cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // track which tap each VFAT's delay line currently holds
  always @(posedge clock) begin
    if (reset_i) begin
      for (int v = 0; v < NV; v++) cur_tap[v] <= 5'd0;
    end else if (tap_load && tap_vfat < NV) begin
      cur_tap[tap_vfat] <= tap_value;
    end
  end

  // err reflects the quality of the currently loaded tap
  always_comb begin
    err = '0;
    for (int v = 0; v < NV; v++) err[v] = bad[v][cur_tap[v]];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clock) begin
    if (!reset_i) begin
      if (tap_load) begin
        if (forbid5) check("tap_load_to_disabled_vfat5", int'(tap_vfat == 5'd5), 0);
        if (exp_q.size() == 0) begin
          check("tap_load_unexpected", 1, 0);
        end else begin
          load_t e;
          e = exp_q.pop_front();
          check("tap_load_vfat", int'(tap_vfat), e.vfat);
          check("tap_load_value", int'(tap_value), e.value);
        end
      end
      if (done) begin
        check("busy_low_at_done", int'(busy), 0);
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  function automatic int tap_cycles(input int v, input int t);
    int c;
    c = WIN;
`ifdef SBIT_TAP_SCAN_EARLY_EXIT_EN
    if (bad[v][t]) c = (THR + 1 < WIN) ? THR + 1 : WIN;
`endif
    return 1 + SETTLE + c + 1;
  endfunction

  // Reference model: longest all-good window found by trying lengths from
  // 32 downwards and starts from 0 upwards.
  task automatic model_scan(input logic [NV-1:0] en, output int cycles);
    cycles = 0;
    for (int v = 0; v < NV; v++) begin
      if (en[v]) begin
        int bl, bs, c;
        bl = 0; bs = 0;
        cycles += 3;
        for (int t = 0; t < 32; t++) begin
          exp_q.push_back('{vfat: v, value: t});
          cycles += tap_cycles(v, t);
        end
        for (int l = 32; l >= 1 && bl == 0; l--) begin
          for (int s = 0; s + l <= 32 && bl == 0; s++) begin
            bit ok;
            ok = 1'b1;
            for (int k = s; k < s + l; k++) if (bad[v][k]) ok = 1'b0;
            if (ok) begin bl = l; bs = s; end
          end
        end
        c = (bl > 0) ? bs + (bl - 1) / 2 : 0;
        exp_q.push_back('{vfat: v, value: c});
        exp_center[v] = c;
        exp_valid[v]  = (bl > 0) ? 1 : 0;
      end else begin
        cycles += 2;
      end
    end
  endtask

  task automatic check_results(input string tag);
    for (int v = 0; v < NV; v++) begin
      rd_vfat = v[4:0];
      #1;
      check({tag, "_rd_center"}, int'(rd_center), exp_center[v]);
      check({tag, "_rd_valid"}, int'(rd_valid), exp_valid[v]);
    end
  endtask

  task automatic run_scan(input logic [NV-1:0] en, input bit noisy, input string tag);
    int cycles, start_cyc;
    model_scan(en, cycles);
    vfat_enable = en;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start_cyc = cyc;
    done_q.push_back(start_cyc + cycles);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy_after_start"}, int'(busy), 1);
    got_done = 1'b0;
    for (int i = 0; i < cycles + 100 && !got_done; i++) begin
      @(negedge clock);
      if (done) begin
        got_done = 1'b1;
        start = 1'b0;
      end else begin
        start = (noisy && (i % 53 == 7)) ? 1'b1 : 1'b0;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      check({tag, "_done_timeout"}, 0, 1);
      done_q.delete();
    end
    check({tag, "_loads_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
    check_results(tag);
  endtask

  function automatic logic [31:0] good_run(input int s, input int e);
    logic [31:0] m;
    m = '0;
    for (int k = s; k <= e; k++) m[k] = 1'b1;
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, s, l;
    logic [NV-1:0] en;
    reset_i = 1'b1; start = 1'b0; vfat_enable = '0; rd_vfat = 5'd0;
    for (int v = 0; v < NV; v++) begin
      bad[v] = 32'hFFFF_FFFF; exp_center[v] = 0; exp_valid[v] = 0;
    end
    repeat (3) @(negedge clock);
    check("rst_tap_load", int'(tap_load), 0);
    check("rst_tap_vfat", int'(tap_vfat), 0);
    check("rst_tap_value", int'(tap_value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_results("rst");
    @(negedge clock);
    reset_i = 1'b0;

    // one run 8..20 on VFAT 0 -> centre 14; start pulses during the scan
    bad[0] = ~good_run(8, 20);
    run_scan(24'h000001, 1'b1, "run8_20");

    // equal runs (earlier wins), run open at tap 31, and no good tap at all
    bad[0] = ~(good_run(2, 5) | good_run(20, 23));
    bad[1] = ~good_run(25, 31);
    bad[2] = 32'hFFFF_FFFF;
    run_scan(24'h000007, 1'b0, "ties_open_allbad");

    // results for VFAT 5, then a scan that must not touch it
    bad[5] = ~good_run(10, 17);
    bad[0] = ~good_run(0, 3);
    run_scan(24'h000021, 1'b0, "prep5");
    bad[0] = ~good_run(28, 31);
    bad[5] = 32'hFFFF_FFFF;
    forbid5 = 1'b1;
    run_scan(24'h000001, 1'b0, "skip5");
    forbid5 = 1'b0;

    // randomized patterns on up to two VFATs per scan
    for (int r = 0; r < 4; r++) begin
      en = '0;
      en[$urandom_range(0, NV - 1)] = 1'b1;
      en[$urandom_range(0, NV - 1)] = 1'b1;
      for (int v = 0; v < NV; v++) begin
        case ($urandom_range(0, 3))
          0: bad[v] = $urandom();
          1: begin
            s = $urandom_range(0, 31);
            l = $urandom_range(1, 32 - s);
            bad[v] = $urandom() & ~good_run(s, s + l - 1);
          end
          2: bad[v] = 32'h0000_0000;
          default: bad[v] = 32'hFFFF_FFFF;
        endcase
      end
      run_scan(en, 1'b0, "random");
    end

    // reset mid-COUNT on VFAT 3 (tap 2 window)
    bad[3] = ~good_run(4, 9);
    model_scan(24'h000008, ncyc);
    vfat_enable = 24'h000008;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (59) @(negedge clock);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_tap_load", int'(tap_load), 0);
    exp_q.delete();
    done_q.delete();
    for (int v = 0; v < NV; v++) begin exp_center[v] = 0; exp_valid[v] = 0; end
    check_results("midrst");
    @(negedge clock);
    @(negedge clock);
    reset_i = 1'b0;
    repeat (30) @(negedge clock);
    check("midrst_stays_idle", int'(busy), 0);

    // recovery scan after the abort
    run_scan(24'h000008, 1'b0, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
